// File: rtl/float_div.sv
// Sequential fp16 divider: restoring radix-2 mantissa division, one quotient bit
// per clock, truncating, no denormals, underflow flushes to zero.
module float_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, NORM = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic [12:0] rem_reg, rem_next;
  logic [11:0] q_reg, q_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        dbz_reg, dbz_next;
  logic [15:0] quot_reg, quot_next;

  logic [12:0] frac_b;
  logic        rem_ge;
  logic [12:0] rem_sub;
  logic        sign;
  logic        a_zero;
  logic        b_zero;
  logic [6:0]  exp_val;
  logic [9:0]  mant;
  logic        exp_under;
  logic        exp_over;

  assign frac_b  = {2'b00, 1'b1, b_reg[9:0]};
  assign rem_ge  = (rem_reg >= frac_b);
  assign rem_sub = rem_ge ? (rem_reg - frac_b) : rem_reg;
  assign sign    = a_reg[15] ^ b_reg[15];
  assign a_zero  = (a_reg[14:0] == 15'd0);
  assign b_zero  = (b_reg[14:0] == 15'd0);

  // Exponent is computed in 7-bit two's complement; its range is -17..46.
  assign exp_val   = {2'b00, a_reg[14:10]} - {2'b00, b_reg[14:10]}
                   + (q_reg[11] ? 7'd15 : 7'd14);
  assign mant      = q_reg[11] ? q_reg[10:1] : q_reg[9:0];
  assign exp_under = exp_val[6] || (exp_val == 7'd0);
  assign exp_over  = !exp_val[6] && (exp_val >= 7'd31);

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    rem_next   = rem_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    dbz_next   = dbz_reg;
    quot_next  = quot_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = dividend;
          b_next     = divisor;
          rem_next   = {2'b00, 1'b1, dividend[9:0]};
          q_next     = 12'd0;
          cnt_next   = 4'd11;
          busy_next  = 1'b1;
          state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        // Quotient bits arrive MSB first, so shifting them in lands bit 11 on top.
        q_next   = {q_reg[10:0], rem_ge};
        rem_next = {rem_sub[11:0], 1'b0};
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd0) begin
          state_next = NORM;
        end
      end
      NORM: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        dbz_next   = b_zero;
        if (b_zero) begin
          quot_next = {sign, 5'h1F, 10'h000};
        end else if (a_zero || exp_under) begin
          quot_next = 16'h0000;
        end else if (exp_over) begin
          quot_next = {sign, 5'h1F, 10'h000};
        end else begin
          quot_next = {sign, exp_val[4:0], mant};
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= 16'h0000;
      b_reg     <= 16'h0000;
      rem_reg   <= 13'd0;
      q_reg     <= 12'd0;
      cnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
      quot_reg  <= 16'h0000;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      rem_reg   <= rem_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      dbz_reg   <= dbz_next;
      quot_reg  <= quot_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign quotient    = quot_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_float_div.sv
// Scoreboard bench for float_div: stimulus pushes expected results with their due
// cycle, an independent monitor pops and compares on every done pulse.
module tb_float_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic        div_by_zero;

  float_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: exact integer quotient of the significands, then the
  // exponent/priority rules of the number format.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int   fa, fb, q, e, m;
    s = a[15] ^ b[15];
    if (b[14:0] == 15'd0) return {1'b1, s, 5'h1F, 10'h000};
    if (a[14:0] == 15'd0) return 17'h00000;
    fa = 1024 + int'(a[9:0]);
    fb = 1024 + int'(b[9:0]);
    q  = (fa * 2048) / fb;
    if (q >= 2048) begin
      m = (q / 2) % 1024;
      e = int'(a[14:10]) - int'(b[14:10]) + 15;
    end else begin
      m = q % 1024;
      e = int'(a[14:10]) - int'(b[14:10]) + 14;
    end
    if (e <= 0) return 17'h00000;
    if (e >= 31) return {1'b0, s, 5'h1F, 10'h000};
    return {1'b0, s, 5'(e), 10'(m)};
  endfunction

  // Monitor: compare on done, and flag results that never arrived on time.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0 && !done && cyc > sb[0].due) begin
      exp_t e;
      e = sb.pop_front();
      chk("missing_done", 32'(cyc), 32'(e.due));
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %h / %h -> %h dbz=%0b (expect %h dbz=%0b) at cycle %0d",
                 e.a, e.b, quotient, div_by_zero, e.q, e.dbz, cyc);
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [16:0] expv);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    e.a   = a;
    e.b   = b;
    e.q   = expv[15:0];
    e.dbz = expv[16];
    e.due = cyc + 13;
    sb.push_back(e);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  task automatic do_reset(input int n);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'h0000);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  logic [15:0] ra, rb;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 16'h0000;
    do_reset(3);

    issue(16'h3C00, 16'h3C00, 17'h03C00);
    issue(16'h4600, 16'h4000, 17'h04200);
    issue(16'hC600, 16'h4000, 17'h0C200);
    issue(16'h3C00, 16'h4200, 17'h03555);
    issue(16'h3C00, 16'h0000, 17'h17C00);
    issue(16'h8000, 16'h0000, 17'h1FC00);
    issue(16'h0000, 16'h4000, 17'h00000);
    issue(16'h0400, 16'h4000, 17'h00000);
    issue(16'h7800, 16'h3800, 17'h07C00);
    drain();

    // Start pulses at 5 and 13 cycles after acceptance must be ignored.
    issue(16'h4600, 16'h4000, 17'h04200);
    repeat (5) @(posedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Back-to-back: the second issue lands in the done cycle of the first.
    issue(16'h3C00, 16'h4200, 17'h03555);
    issue(16'hC600, 16'h4000, 17'h0C200);
    drain();

    // Reset during DIVIDE aborts; any later done would be spurious.
    issue(16'h4600, 16'h4000, 17'h04200);
    repeat (6) @(posedge clk);
    do_reset(1);
    repeat (20) @(negedge clk);
    issue(16'h3C00, 16'h4200, 17'h03555);
    drain();

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ra[14:0] = 15'd0;
      if ($urandom_range(0, 9) == 0) rb[14:0] = 15'd0;
      if ($urandom_range(0, 1) == 0) begin
        ra[14:10] = 5'($urandom_range(8, 22));
        rb[14:10] = 5'($urandom_range(8, 22));
      end
      issue(ra, rb, model(ra, rb));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
